// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types, constants and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int NR_REQ = 4;
    localparam int SEL_W  = 2;

    typedef logic [NR_REQ-1:0] req_t;
    typedef logic [SEL_W-1:0]  sel_t;

    // The output register is either holding an unconsumed word or not.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Select index to one-hot grant vector.
    function automatic req_t onehot2(input sel_t sel);
        onehot2 = req_t'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and consumer-side signals of the arbiter bundled together.
// The arbiter uses the slave view; the producers/consumer use the master view.
interface rr_mux_arbiter_if
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATA_W = 2
);
    req_t                     req;
    logic [NR_REQ*DATA_W-1:0] data_i;
    req_t                     gnt;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    sel_t                     out_src;

    modport master (
        output req, data_i, out_ready,
        input  gnt, out_valid, out_data, out_src
    );

    modport slave (
        input  req, data_i, out_ready,
        output gnt, out_valid, out_data, out_src
    );
endinterface

// File: rtl/MuxKey.sv
// Key-matched selector: lut holds NR_KEY {key, data} pairs; the output is
// the data of the pair whose key equals the input key, zero if none match.
// Only the matching pair reaches the output, so unselected data is ignored.
module MuxKey #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                  out,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // Scan all pairs and forward the data of the one whose key matches.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves it unassigned would infer a latch.
        out = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
                out = lut[i*PAIR_LEN +: DATA_LEN];
            end
        end
    end
endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin winner search: scan last_ptr+1, +2, +3, then last_ptr itself
// (mod 4) and report the first index with its request asserted.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  req_t req,
    input  sel_t last_ptr,
    output logic any,
    output sel_t winner
);
    // First asserted request in rotating priority order wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int i = 1; i <= NR_REQ; i++) begin
            if (!any && req[sel_t'(last_ptr + sel_t'(i))]) begin
                any    = 1'b1;
                winner = sel_t'(last_ptr + sel_t'(i));
            end
        end
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 MuxKey selector between four
// requesters. The granted word is captured into an output register and
// offered downstream through a valid/ready handshake.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    rr_mux_arbiter_if.slave   bus
);
    localparam int PAIR_W = SEL_W + DATA_W;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    sel_t              src_q, src_d;
    sel_t              last_ptr_q, last_ptr_d;

    logic              any;
    sel_t              winner;
    logic [DATA_W-1:0] mux_out;
    logic [NR_REQ*PAIR_W-1:0] lut;
    logic              can_load;
    logic              capture;

    // A new word may enter when the register is empty or is being drained
    // this very cycle; reset suppresses any grant.
    assign can_load = (state_q == EMPTY) || bus.out_ready;
    assign capture  = !rst && can_load && any;

    rr_pick u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr_q),
        .any      (any),
        .winner   (winner)
    );

    // Build the {key, word} table: key n selects requester n's word.
    always_comb begin
        lut = '0;
        for (int n = 0; n < NR_REQ; n++) begin
            lut[n*PAIR_W +: PAIR_W] = {sel_t'(n), bus.data_i[n*DATA_W +: DATA_W]};
        end
    end

    MuxKey #(
        .NR_KEY   (NR_REQ),
        .KEY_LEN  (SEL_W),
        .DATA_LEN (DATA_W)
    ) u_mux (
        .out (mux_out),
        .key (winner),
        .lut (lut)
    );

    // Next-state: capture on grant, drain on accept without a new request,
    // otherwise hold everything (including priority).
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        src_d      = src_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            EMPTY: begin
                if (capture) begin
                    state_d    = FULL;
                    data_d     = mux_out;
                    src_d      = winner;
                    last_ptr_d = winner;
                end
            end
            FULL: begin
                if (capture) begin
                    data_d     = mux_out;
                    src_d      = winner;
                    last_ptr_d = winner;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register with synchronous reset; last_ptr=3 gives requester 0
    // first priority after reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (rst) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            src_q      <= '0;
            last_ptr_q <= sel_t'(NR_REQ - 1);
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            src_q      <= src_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    assign bus.gnt       = capture ? onehot2(winner) : '0;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: reset, single request, drain,
// round-robin rotation, backpressure and reset mid-transfer.
module tb_rr_mux_arbiter;
    import rr_mux_arbiter_pkg::*;

    localparam int DATA_W = 2;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    // Hand-computed rotation with all four requests held from reset.
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.DATA_W(DATA_W)) bus ();

    rr_mux_arbiter #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] gnt, input logic valid,
                             input logic [1:0] data, input logic [1:0] src);
        check({tag, ".gnt"},       8'(bus.gnt),       8'(gnt));
        check({tag, ".out_valid"}, 8'(bus.out_valid), 8'(valid));
        check({tag, ".out_data"},  8'(bus.out_data),  8'(data));
        check({tag, ".out_src"},   8'(bus.out_src),   8'(src));
    endtask

    // Drive point: just after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample point: falling edge, away from the capturing edge.
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.data_i    = 8'b11_10_01_00;
        bus.out_ready = 1'b1;

        // Reset held two cycles with all requests up: no grant, all zero.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            check_all("reset", 4'b0000, 1'b0, 2'b00, 2'd0);
        end

        // Single request from requester 2.
        next_cycle();
        rst        = 1'b0;
        bus.req    = 4'b0100;
        bus.data_i = 8'b00_10_00_00;
        sample();
        check_all("single.grant", 4'b0100, 1'b0, 2'b00, 2'd0);
        next_cycle();
        bus.req = 4'b0000;
        sample();
        check_all("single.out", 4'b0000, 1'b1, 2'b10, 2'd2);

        // Drain: accepted with no request pending, data holds.
        next_cycle();
        sample();
        check_all("drain", 4'b0000, 1'b0, 2'b10, 2'd2);

        // Reset pulse to restore requester 0 priority.
        next_cycle();
        rst        = 1'b1;
        bus.req    = 4'b1111;
        bus.data_i = 8'b11_10_01_00;
        sample();
        check("rst_pulse.gnt", 8'(bus.gnt), 8'h00);

        // Round robin with all requests held and ready high.
        next_cycle();
        rst = 1'b0;
        sample();
        check_all("rr0", exp_gnt[0], 1'b0, 2'b00, 2'd0);
        for (int k = 1; k < 5; k++) begin
            next_cycle();
            sample();
            check_all($sformatf("rr%0d", k), exp_gnt[k], 1'b1, exp_src[k-1], exp_src[k-1]);
        end
        next_cycle();
        sample();
        check_all("rr_last", 4'b0010, 1'b1, 2'b00, 2'd0);

        // Backpressure: requester 1 captured, then three stalled cycles.
        next_cycle();
        bus.out_ready = 1'b0;
        sample();
        check_all("stall0", 4'b0000, 1'b1, 2'b01, 2'd1);
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            sample();
            check_all($sformatf("stall%0d", i), 4'b0000, 1'b1, 2'b01, 2'd1);
        end
        next_cycle();
        bus.out_ready = 1'b1;
        sample();
        check_all("release", 4'b0100, 1'b1, 2'b01, 2'd1);

        // Reset mid-transfer while a word is stalled.
        next_cycle();
        bus.out_ready = 1'b0;
        sample();
        check_all("pending", 4'b0000, 1'b1, 2'b10, 2'd2);
        next_cycle();
        rst = 1'b1;
        sample();
        check_all("mid_rst", 4'b0000, 1'b1, 2'b10, 2'd2);
        next_cycle();
        rst           = 1'b0;
        bus.req       = 4'b1010;
        bus.out_ready = 1'b1;
        sample();
        check_all("post_rst", 4'b0010, 1'b0, 2'b00, 2'd0);
        next_cycle();
        sample();
        check_all("post_rst.out", 4'b1000, 1'b1, 2'b01, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
